// File: rtl/pix_axis_rx_pkg.sv
// pix_axis_rx_pkg
//   Shared types and defaults for the pixel AXI4-Stream receive path.
//   - rx_state_t      : receive FSM states (IDLE / RUN / DRAIN)
//   - IMG_W_DEF etc.  : default frame geometry and packet length. The output
//                       stage uses the same PKT_LEN_DEF so both ends of the
//                       DMA link agree on packet framing.
//   - cnt_width()     : counter width for a 0..n-1 counter, never below 1 bit
package pix_axis_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rx_state_t;

    localparam int IMG_W_DEF      = 1024;
    localparam int IMG_H_DEF      = 768;
    localparam int PKT_LEN_DEF    = 128;
    localparam int FIFO_DEPTH_DEF = 16;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_cnt.sv
// sync_fifo_cnt
//   Synchronous FIFO with occupancy count. Read data is presented
//   combinationally from the head entry (first-word fall-through), so a read
//   strobe in a cycle consumes the word visible in that same cycle.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset (flushes FIFO)
//     wr_en, wr_data    : write request; ignored while full
//     rd_en, rd_data    : read request; ignored while empty; rd_data = head
//     count             : registered occupancy 0..DEPTH
//     full, empty       : decoded from count
//   DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo_cnt
    import pix_axis_rx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = cnt_width(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            // Simultaneous read and write leaves the occupancy unchanged.
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/pix_axis_rx.sv
// pix_axis_rx
//   AXI4-Stream slave receiving 8-bit grayscale pixels from the DMA and
//   feeding the edge-detection pipeline one pixel per pipe_ready cycle.
//   Handshake: a beat transfers in every cycle where s_axis_tvalid and
//   s_axis_tready are both high at the rising clock edge; s_axis_tready is a
//   function of FSM state and registered FIFO occupancy only, never of tvalid.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     s_axis_tdata    : pixel beat
//     s_axis_tvalid   : beat valid
//     s_axis_tlast    : packet end (expected every PKT_LEN beats)
//     s_axis_tready   : slave ready
//     pipe_ready      : downstream can take a pixel this cycle
//     pix_en          : one-cycle strobe qualifying pix_data and markers
//     pix_data        : pixel to pipeline
//     pix_sof/eol/eof : first-of-frame / last-of-line / last-of-frame markers
//     frame_done      : one-cycle pulse the cycle after the eof pixel
//     err_last        : sticky tlast framing error, cleared only by rst
module pix_axis_rx
    import pix_axis_rx_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF,
    parameter int PKT_LEN    = PKT_LEN_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    input  logic       s_axis_tlast,
    output logic       s_axis_tready,
    input  logic       pipe_ready,
    output logic       pix_en,
    output logic [7:0] pix_data,
    output logic       pix_sof,
    output logic       pix_eol,
    output logic       pix_eof,
    output logic       frame_done,
    output logic       err_last
);

    localparam int FRM_N = IMG_W * IMG_H;
    localparam int COL_W = cnt_width(IMG_W);
    localparam int ROW_W = cnt_width(IMG_H);
    localparam int FRM_W = cnt_width(FRM_N);
    localparam int PKT_W = cnt_width(PKT_LEN);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [FRM_W-1:0] beat_cnt;
    logic [PKT_W-1:0] pkt_cnt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rd_data;

    logic accept;
    logic fifo_rd;
    logic last_beat;
    logic pkt_end_exp;

    // ------------------------------------------------------------------
    // Input side
    // ------------------------------------------------------------------
    // Ready is low during the reset cycle, in DRAIN, and once the registered
    // occupancy reaches the depth; there is no write bypass when full.
    assign s_axis_tready = !rst && (state != ST_DRAIN) &&
                           (fifo_count != CNT_W'(FIFO_DEPTH));
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign fifo_rd       = pipe_ready && !fifo_empty;
    assign last_beat     = (beat_cnt == FRM_W'(FRM_N - 1));
    assign pkt_end_exp   = (pkt_cnt == PKT_W'(PKT_LEN - 1));

    sync_fifo_cnt #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        // tready already excludes full; the extra guard keeps the FIFO safe
        // should the ready term ever be loosened.
        .wr_en   (accept && !fifo_full),
        .wr_data (s_axis_tdata),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (accept) state_nxt = last_beat ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (accept && last_beat) state_nxt = ST_DRAIN;
            // Leave DRAIN while frame_done is high so tready returns the
            // cycle after the pulse.
            ST_DRAIN: if (frame_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Frame beat counter and tlast framing check.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            pkt_cnt  <= '0;
            err_last <= 1'b0;
        end else begin
            if (accept)
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            else if (state == ST_DRAIN && state_nxt == ST_IDLE)
                beat_cnt <= '0;

            if (accept) begin
                if (s_axis_tlast != pkt_end_exp)
                    err_last <= 1'b1;
                // Any accepted tlast restarts the packet, so a framing slip
                // is reported once and later packets are judged afresh.
                if (s_axis_tlast || pkt_end_exp)
                    pkt_cnt <= '0;
                else
                    pkt_cnt <= pkt_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output side
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_en     <= 1'b0;
            pix_data   <= 8'h00;
            frame_done <= 1'b0;
            col        <= '0;
            row        <= '0;
        end else begin
            pix_en     <= fifo_rd;
            if (fifo_rd) pix_data <= fifo_rd_data;
            frame_done <= pix_en && pix_eof;
            // col/row describe the pixel currently on pix_data and step
            // once that pixel has been presented.
            if (pix_en) begin
                if (col == COL_W'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign pix_sof = pix_en && (col == '0) && (row == '0);
    assign pix_eol = pix_en && (col == COL_W'(IMG_W - 1));
    assign pix_eof = pix_eol && (row == ROW_W'(IMG_H - 1));

endmodule

// File: tb/tb_pix_axis_rx.sv
// tb_pix_axis_rx
//   Directed bench for pix_axis_rx. Instance "dut" uses a 4x2 frame with
//   4-beat packets; instance "dut_b" uses an 8x4 frame so a full 16-entry
//   FIFO can be reached without hitting end of frame.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_pix_axis_rx;

    logic       clk;
    logic       rst;

    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tlast;
    logic       s_axis_tready;
    logic       pipe_ready;
    logic       pix_en;
    logic [7:0] pix_data;
    logic       pix_sof, pix_eol, pix_eof;
    logic       frame_done;
    logic       err_last;

    logic [7:0] b_tdata;
    logic       b_tvalid;
    logic       b_tlast;
    logic       b_tready;
    logic       b_pipe_ready;
    logic       b_pix_en;
    logic [7:0] b_pix_data;
    logic       b_pix_sof, b_pix_eol, b_pix_eof;
    logic       b_frame_done;
    logic       b_err_last;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];

    pix_axis_rx #(.IMG_W(4), .IMG_H(2), .PKT_LEN(4), .FIFO_DEPTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .pipe_ready    (pipe_ready),
        .pix_en        (pix_en),
        .pix_data      (pix_data),
        .pix_sof       (pix_sof),
        .pix_eol       (pix_eol),
        .pix_eof       (pix_eof),
        .frame_done    (frame_done),
        .err_last      (err_last)
    );

    pix_axis_rx #(.IMG_W(8), .IMG_H(4), .PKT_LEN(4), .FIFO_DEPTH(16)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (b_tdata),
        .s_axis_tvalid (b_tvalid),
        .s_axis_tlast  (b_tlast),
        .s_axis_tready (b_tready),
        .pipe_ready    (b_pipe_ready),
        .pix_en        (b_pix_en),
        .pix_data      (b_pix_data),
        .pix_sof       (b_pix_sof),
        .pix_eol       (b_pix_eol),
        .pix_eof       (b_pix_eof),
        .frame_done    (b_frame_done),
        .err_last      (b_err_last)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input logic v, input logic [7:0] d, input logic l);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive_beat(1'b0, 8'h00, 1'b0);
        pipe_ready = 1'b0;
        b_tvalid = 1'b0; b_tdata = 8'h00; b_tlast = 1'b0; b_pipe_ready = 1'b0;
        step();
        n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready got %b exp 0", s_axis_tready); end
        n_checks++; if (pix_en !== 1'b0) begin n_fail++; $display("FAIL reset_pix_en got %b exp 0", pix_en); end
        n_checks++; if (pix_data !== 8'h00) begin n_fail++; $display("FAIL reset_pix_data got %h exp 00", pix_data); end
        n_checks++; if ({pix_sof, pix_eol, pix_eof} !== 3'b000) begin n_fail++; $display("FAIL reset_markers got %b exp 000", {pix_sof, pix_eol, pix_eof}); end
        n_checks++; if ({frame_done, err_last} !== 2'b00) begin n_fail++; $display("FAIL reset_fd_err got %b exp 00", {frame_done, err_last}); end
        n_checks++; if (b_tready !== 1'b0) begin n_fail++; $display("FAIL reset_b_tready got %b exp 0", b_tready); end
        rst = 1'b0;
        pipe_ready = 1'b1;
        b_pipe_ready = 1'b1;
        step();
        n_checks++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL idle_tready got %b exp 1", s_axis_tready); end
        n_checks++; if (b_tready !== 1'b1) begin n_fail++; $display("FAIL idle_b_tready got %b exp 1", b_tready); end
        n_checks++; if (pix_en !== 1'b0) begin n_fail++; $display("FAIL idle_pix_en got %b exp 0", pix_en); end
    endtask

    // Beats 0x10..0x17, tlast on beats 3 and 7; beat k is driven in
    // iteration k and pixel k appears in iteration k+2.
    task automatic test_frame();
        logic       exp_en;
        logic [7:0] exp_d;
        for (int k = 0; k < 14; k++) begin
            exp_en = (k >= 2 && k <= 9);
            exp_d  = 8'h10 + 8'(k - 2);
            n_checks++; if (pix_en !== exp_en) begin n_fail++; $display("FAIL frame_pix_en k=%0d got %b exp %b", k, pix_en, exp_en); end
            if (exp_en) begin
                n_checks++; if (pix_data !== exp_d) begin n_fail++; $display("FAIL frame_pix_data k=%0d got %h exp %h", k, pix_data, exp_d); end
            end
            n_checks++;
            if ({pix_sof, pix_eol, pix_eof} !== {exp_en && k == 2, exp_en && (k == 5 || k == 9), k == 9}) begin
                n_fail++; $display("FAIL frame_markers k=%0d got %b", k, {pix_sof, pix_eol, pix_eof});
            end
            n_checks++; if (frame_done !== (k == 10)) begin n_fail++; $display("FAIL frame_done k=%0d got %b exp %b", k, frame_done, k == 10); end
            n_checks++; if (s_axis_tready !== !(k >= 8 && k <= 10)) begin n_fail++; $display("FAIL frame_tready k=%0d got %b", k, s_axis_tready); end
            n_checks++; if (err_last !== 1'b0) begin n_fail++; $display("FAIL frame_err k=%0d got %b exp 0", k, err_last); end
            if (k < 8) drive_beat(1'b1, 8'h10 + 8'(k), (k == 3 || k == 7));
            else       drive_beat(1'b0, 8'h00, 1'b0);
            step();
        end
    endtask

    // tvalid held high across two frames; ready must fall for DRAIN.
    task automatic test_drain();
        int         sent;
        int         pix_cnt;
        int         fd_cnt;
        logic [7:0] exp_d;
        exp_q.delete();
        sent = 0; pix_cnt = 0; fd_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            if (pix_en) begin
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                n_checks++; if (pix_data !== exp_d) begin n_fail++; $display("FAIL drain_data k=%0d got %h exp %h", k, pix_data, exp_d); end
                n_checks++; if (pix_sof !== (pix_cnt % 8 == 0)) begin n_fail++; $display("FAIL drain_sof k=%0d got %b exp %b", k, pix_sof, pix_cnt % 8 == 0); end
                pix_cnt++;
            end
            if (k == 13) begin
                n_checks++; if ({pix_en, pix_sof} !== 2'b11) begin n_fail++; $display("FAIL drain_second_sof got %b exp 11", {pix_en, pix_sof}); end
            end
            if (frame_done) fd_cnt++;
            n_checks++;
            if (s_axis_tready !== !((k >= 8 && k <= 10) || (k >= 19 && k <= 21))) begin
                n_fail++; $display("FAIL drain_tready k=%0d got %b", k, s_axis_tready);
            end
            drive_beat(sent < 16, 8'h20 + 8'(sent), (sent % 4 == 3));
            if (s_axis_tvalid && s_axis_tready) begin
                exp_q.push_back(s_axis_tdata);
                sent++;
            end
            step();
        end
        drive_beat(1'b0, 8'h00, 1'b0);
        n_checks++; if (pix_cnt != 16) begin n_fail++; $display("FAIL drain_pix_count got %0d exp 16", pix_cnt); end
        n_checks++; if (fd_cnt != 2) begin n_fail++; $display("FAIL drain_frame_done_count got %0d exp 2", fd_cnt); end
        n_checks++; if (err_last !== 1'b0) begin n_fail++; $display("FAIL drain_err got %b exp 0", err_last); end
    endtask

    // tlast on beat 2 (early), then on beat 6 after the packet restart.
    task automatic test_framing_error();
        logic       exp_en;
        logic [7:0] exp_d;
        for (int k = 0; k < 14; k++) begin
            exp_en = (k >= 2 && k <= 9);
            exp_d  = 8'h50 + 8'(k - 2);
            n_checks++; if (err_last !== (k >= 3)) begin n_fail++; $display("FAIL ferr_err k=%0d got %b exp %b", k, err_last, k >= 3); end
            n_checks++; if (pix_en !== exp_en) begin n_fail++; $display("FAIL ferr_pix_en k=%0d got %b exp %b", k, pix_en, exp_en); end
            if (exp_en) begin
                n_checks++; if (pix_data !== exp_d) begin n_fail++; $display("FAIL ferr_data k=%0d got %h exp %h", k, pix_data, exp_d); end
            end
            n_checks++; if (frame_done !== (k == 10)) begin n_fail++; $display("FAIL ferr_frame_done k=%0d got %b", k, frame_done); end
            if (k < 8) drive_beat(1'b1, 8'h50 + 8'(k), (k == 2 || k == 6));
            else       drive_beat(1'b0, 8'h00, 1'b0);
            step();
        end
    endtask

    // Downstream stalled 20 cycles on the 8x4 instance.
    task automatic test_backpressure();
        int         sent;
        int         idx;
        logic       exp_en;
        logic [7:0] exp_d;
        sent = 0;
        for (int k = 0; k < 38; k++) begin
            exp_en = (k >= 21 && k <= 36);
            idx    = k - 21;
            exp_d  = 8'h40 + 8'(idx);
            if (k < 20) begin
                n_checks++; if (b_tready !== (k < 16)) begin n_fail++; $display("FAIL bp_tready k=%0d got %b exp %b", k, b_tready, k < 16); end
            end
            n_checks++; if (b_pix_en !== exp_en) begin n_fail++; $display("FAIL bp_pix_en k=%0d got %b exp %b", k, b_pix_en, exp_en); end
            if (exp_en) begin
                n_checks++; if (b_pix_data !== exp_d) begin n_fail++; $display("FAIL bp_data k=%0d got %h exp %h", k, b_pix_data, exp_d); end
                n_checks++;
                if ({b_pix_sof, b_pix_eol} !== {idx == 0, idx == 7 || idx == 15}) begin
                    n_fail++; $display("FAIL bp_markers k=%0d got %b", k, {b_pix_sof, b_pix_eol});
                end
            end
            b_pipe_ready = (k >= 20);
            b_tvalid     = (k < 20);
            b_tdata      = 8'h40 + 8'(sent);
            b_tlast      = (sent % 4 == 3);
            if (b_tvalid && b_tready) sent++;
            step();
        end
        b_tvalid = 1'b0;
        n_checks++; if (sent != 16) begin n_fail++; $display("FAIL bp_accept_count got %0d exp 16", sent); end
        n_checks++; if (b_err_last !== 1'b0) begin n_fail++; $display("FAIL bp_err got %b exp 0", b_err_last); end
    endtask

    // Reset after 5 buffered beats, then a clean frame 0x70..0x77.
    task automatic test_mid_reset();
        logic       exp_en;
        logic [7:0] exp_d;
        n_checks++; if (err_last !== 1'b1) begin n_fail++; $display("FAIL mr_err_before got %b exp 1", err_last); end
        pipe_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_beat(1'b1, 8'h60 + 8'(k), (k == 3));
            step();
        end
        drive_beat(1'b0, 8'h00, 1'b0);
        pipe_ready = 1'b1;
        rst = 1'b1;
        step();
        n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL mr_tready got %b exp 0", s_axis_tready); end
        n_checks++; if ({pix_en, pix_sof, pix_eol, pix_eof} !== 4'b0000) begin n_fail++; $display("FAIL mr_pix got %b exp 0000", {pix_en, pix_sof, pix_eol, pix_eof}); end
        n_checks++; if (pix_data !== 8'h00) begin n_fail++; $display("FAIL mr_pix_data got %h exp 00", pix_data); end
        n_checks++; if ({frame_done, err_last} !== 2'b00) begin n_fail++; $display("FAIL mr_fd_err got %b exp 00", {frame_done, err_last}); end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++; if (pix_en !== 1'b0) begin n_fail++; $display("FAIL mr_flushed k=%0d got %b exp 0", k, pix_en); end
            n_checks++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL mr_idle_tready k=%0d got %b exp 1", k, s_axis_tready); end
        end
        for (int k = 0; k < 14; k++) begin
            exp_en = (k >= 2 && k <= 9);
            exp_d  = 8'h70 + 8'(k - 2);
            n_checks++; if (pix_en !== exp_en) begin n_fail++; $display("FAIL mr_pix_en k=%0d got %b exp %b", k, pix_en, exp_en); end
            if (exp_en) begin
                n_checks++; if (pix_data !== exp_d) begin n_fail++; $display("FAIL mr_data k=%0d got %h exp %h", k, pix_data, exp_d); end
            end
            n_checks++;
            if ({pix_sof, pix_eol, pix_eof} !== {exp_en && k == 2, exp_en && (k == 5 || k == 9), k == 9}) begin
                n_fail++; $display("FAIL mr_markers k=%0d got %b", k, {pix_sof, pix_eol, pix_eof});
            end
            n_checks++; if (frame_done !== (k == 10)) begin n_fail++; $display("FAIL mr_frame_done k=%0d got %b", k, frame_done); end
            n_checks++; if (s_axis_tready !== !(k >= 8 && k <= 10)) begin n_fail++; $display("FAIL mr_tready k=%0d got %b", k, s_axis_tready); end
            if (k < 8) drive_beat(1'b1, 8'h70 + 8'(k), (k == 3 || k == 7));
            else       drive_beat(1'b0, 8'h00, 1'b0);
            step();
        end
        n_checks++; if (err_last !== 1'b0) begin n_fail++; $display("FAIL mr_err_after got %b exp 0", err_last); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_frame();
        test_drain();
        test_framing_error();
        test_backpressure();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
